// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter: operation encoding,
// per-stage control word and the illegal-operation check.
package shifter_pkg;

  localparam int TYPE_W = 3;

  typedef enum logic [TYPE_W-1:0] {
    SRL = 3'd0,
    SLL = 3'd1,
    SRA = 3'd2,
    ROR = 3'd3,
    ROL = 3'd4
  } shift_type_e;

  // Control word carried alongside data/shamt/tag in every stage register.
  typedef struct packed {
    logic              vld;
    logic [TYPE_W-1:0] op;
    logic              sign;
    logic              err;
  } stage_ctl_t;

  function automatic logic is_illegal(input logic [TYPE_W-1:0] op);
    return op > ROL;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One shifter stage: shifts by its owned shamt bits [LO_BIT +: NBITS], then registers.
// Latency 1 cycle; holds while adv is low, reset/flush clear the valid bit.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int TAG_W   = 5,
  parameter int LO_BIT  = 0,
  parameter int NBITS   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               adv,
  input  stage_ctl_t         d_ctl,
  input  logic [WIDTH-1:0]   d_data,
  input  logic [SHAMT_W-1:0] d_shamt,
  input  logic [TAG_W-1:0]   d_tag,
  output stage_ctl_t         q_ctl,
  output logic [WIDTH-1:0]   q_data,
  output logic [SHAMT_W-1:0] q_shamt,
  output logic [TAG_W-1:0]   q_tag
);

  localparam int HI = LO_BIT + NBITS;
  localparam logic [SHAMT_W-1:0] OWN_MASK  = SHAMT_W'(((1 << HI) - 1) & ~((1 << LO_BIT) - 1));
  localparam logic [SHAMT_W-1:0] KEEP_MASK = ~SHAMT_W'((1 << HI) - 1);

  // Masked shamt is a sum of 2^k terms for the owned bits, so one barrel
  // shift by it equals the cascade of conditional power-of-two shifts.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0]  v,
                                                input logic [TYPE_W-1:0] op,
                                                input logic              sign,
                                                input int                amt);
    logic [WIDTH-1:0] r;
    case (op)
      SRL:     r = v >> amt;
      SLL:     r = v << amt;
      SRA:     r = (v >> amt) | ({WIDTH{sign}} << (WIDTH - amt));
      ROR:     r = (v >> amt) | (v << (WIDTH - amt));
      ROL:     r = (v << amt) | (v >> (WIDTH - amt));
      default: r = v;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] shifted;

  assign shifted = shift_by(d_data, d_ctl.op, d_ctl.sign, int'(d_shamt & OWN_MASK));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_ctl   <= '0;
      q_data  <= '0;
      q_shamt <= '0;
      q_tag   <= '0;
    end else if (flush) begin
      q_ctl.vld <= 1'b0;
    end else if (adv) begin
      q_ctl   <= d_ctl;
      q_data  <= shifted;
      q_shamt <= d_shamt & KEEP_MASK;
      q_tag   <= d_tag;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SRL/SLL/SRA/ROR/ROL) with tag sideband.
// Latency PIPE_STAGES cycles; whole pipe stalls when out_valid && !out_ready.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SHAMT_W     = $clog2(WIDTH),
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [2:0]         in_type,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  localparam int BITS_PER = (SHAMT_W + PIPE_STAGES - 1) / PIPE_STAGES;

  // Element 0 is the issue side; element s+1 is the register of stage s.
  stage_ctl_t         ctl   [PIPE_STAGES+1];
  logic [WIDTH-1:0]   data  [PIPE_STAGES+1];
  logic [SHAMT_W-1:0] shamt [PIPE_STAGES+1];
  logic [TAG_W-1:0]   tag   [PIPE_STAGES+1];
  logic               adv;
  logic               illegal;

  assign illegal = is_illegal(in_type);

  // Illegal ops enter with zero data so every later stage yields zero.
  assign ctl[0].vld  = in_valid;
  assign ctl[0].op   = in_type;
  assign ctl[0].sign = in_a[WIDTH-1];
  assign ctl[0].err  = illegal;
  assign data[0]     = illegal ? '0 : in_a;
  assign shamt[0]    = in_shamt;
  assign tag[0]      = in_tag;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
    localparam int LO = s * BITS_PER;
    localparam int NB = (LO >= SHAMT_W) ? 0 :
                        ((SHAMT_W - LO < BITS_PER) ? (SHAMT_W - LO) : BITS_PER);

    shift_stage #(
      .WIDTH  (WIDTH),
      .SHAMT_W(SHAMT_W),
      .TAG_W  (TAG_W),
      .LO_BIT (LO),
      .NBITS  (NB)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .adv    (adv),
      .d_ctl  (ctl[s]),
      .d_data (data[s]),
      .d_shamt(shamt[s]),
      .d_tag  (tag[s]),
      .q_ctl  (ctl[s+1]),
      .q_data (data[s+1]),
      .q_shamt(shamt[s+1]),
      .q_tag  (tag[s+1])
    );
  end

  assign adv        = !ctl[PIPE_STAGES].vld || out_ready;
  assign in_ready   = adv;
  assign out_valid  = ctl[PIPE_STAGES].vld;
  assign out_err    = ctl[PIPE_STAGES].err;
  assign out_result = data[PIPE_STAGES];
  assign out_tag    = tag[PIPE_STAGES];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter (WIDTH=32, PIPE_STAGES=2): directed
// cases, stalls, flush, reset and randomized traffic against an arithmetic model.
module tb_pipelined_shifter;

  typedef struct packed {
    logic [31:0] r;
    logic [4:0]  t;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [31:0] in_a, out_result;
  logic [4:0]  in_shamt, in_tag, out_tag;
  logic [2:0]  in_type;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rand_bp = 1'b0;
  bit   ready_fix = 1'b1;

  pipelined_shifter #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_shamt  (in_shamt),
    .in_type   (in_type),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Reference: each op computed directly from its definition.
  function automatic exp_t model(input logic [31:0] a, input logic [4:0] s,
                                 input logic [2:0] ty, input logic [4:0] tg);
    exp_t        x;
    logic [63:0] dbl;
    x.t = tg;
    x.e = 1'b0;
    dbl = {a, a};
    case (ty)
      3'd0: x.r = a >> s;
      3'd1: x.r = a << s;
      3'd2: x.r = $unsigned($signed(a) >>> s);
      3'd3: begin dbl = dbl >> s; x.r = dbl[31:0];  end
      3'd4: begin dbl = dbl << s; x.r = dbl[63:32]; end
      default: begin x.r = 32'd0; x.e = 1'b1; end
    endcase
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : ready_fix;
  endtask

  task automatic issue(input logic [31:0] a, input logic [4:0] s, input logic [2:0] ty,
                       input logic [4:0] tg, output int tries);
    bit done = 1'b0;
    tries = 0;
    while (!done && tries < 100) begin
      tick();
      in_valid = 1'b1; in_a = a; in_shamt = s; in_type = ty; in_tag = tg;
      tries++;
      #1;
      if (in_ready) begin
        exp_q.push_back(model(a, s, ty, tg));
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL issue_timeout: op not accepted within %0d cycles", tries);
    end
  endtask

  task automatic drain(input string nm);
    int i = 0;
    while (exp_q.size() != 0 && i < 300) begin
      tick();
      #3;
      i++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  // Monitor: compares every output transfer against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_output: result=0x%0h tag=%0d, no op outstanding", out_result, out_tag);
        end else begin
          e = exp_q.pop_front();
          if (out_result !== e.r || out_tag !== e.t || out_err !== e.e) begin
            n_bad++;
            $display("FAIL result: got r=0x%0h t=%0d e=%0b, expected r=0x%0h t=%0d e=%0b",
                     out_result, out_tag, out_err, e.r, e.t, e.e);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   tries;
    exp_t hd;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_shamt = '0;
    in_type = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Latency: result appears exactly two cycles after acceptance.
    issue(32'h0000_00F1, 5'd4, 3'd1, 5'd3, tries);
    tick(); #1 chk("lat_cycle1_valid", out_valid, 0);
    tick(); #1 chk("lat_cycle2_valid", out_valid, 1);
    drain("drain_sll");

    issue(32'h8000_0000, 5'd31, 3'd2, 5'd1, tries);
    issue(32'h8000_0000, 5'd31, 3'd0, 5'd2, tries);
    issue(32'h0000_0001, 5'd1,  3'd3, 5'd4, tries);
    issue(32'h8000_0001, 5'd4,  3'd4, 5'd5, tries);
    issue(32'h1234_5678, 5'd0,  3'd2, 5'd6, tries);
    issue(32'hDEAD_BEEF, 5'd0,  3'd4, 5'd8, tries);
    drain("drain_directed");

    // Back-to-back: one op per cycle in, one result per cycle out.
    for (int k = 0; k < 8; k++) begin
      issue($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), 5'(k), tries);
      chk("b2b_accept_first_try", tries, 1);
    end
    tick(); tick(); #3;
    chk("b2b_all_out", exp_q.size(), 0);

    // Backpressure: stall the output with ops in flight and one waiting.
    ready_fix = 1'b0;
    issue(32'h0F0F_0000, 5'd8, 3'd0, 5'd10, tries);
    issue(32'h0000_00FF, 5'd9, 3'd1, 5'd11, tries);
    for (int k = 0; k < 3; k++) begin
      tick();
      in_valid = 1'b1; in_a = 32'hA5A5_0001; in_shamt = 5'd2; in_type = 3'd3; in_tag = 5'd12;
      #1;
      hd = exp_q[0];
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_result", out_result, hd.r);
      chk("stall_tag", out_tag, 32'(hd.t));
    end
    ready_fix = 1'b1;
    issue(32'hA5A5_0001, 5'd2, 3'd3, 5'd12, tries);
    drain("drain_stall");

    // Illegal type delivers zero result, error flag and the tag.
    issue(32'hFFFF_FFFF, 5'd3, 3'b110, 5'd7, tries);
    issue(32'h1234_5678, 5'd0, 3'b111, 5'd9, tries);
    drain("drain_illegal");

    // Flush with two ops in flight plus one offered in the same cycle.
    issue(32'h0000_1111, 5'd1, 3'd1, 5'd13, tries);
    issue(32'h0000_2222, 5'd2, 3'd1, 5'd14, tries);
    tick();
    flush = 1'b1;
    in_valid = 1'b1; in_a = 32'h3333_3333; in_shamt = 5'd3; in_type = 3'd0; in_tag = 5'd15;
    exp_q.delete();
    tick();
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("flush_no_valid", out_valid, 0);
      tick();
    end

    // Reset mid-stream, then a fresh op must complete normally.
    issue(32'h0000_4444, 5'd1, 3'd0, 5'd16, tries);
    issue(32'h0000_5555, 5'd2, 3'd1, 5'd17, tries);
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_result", out_result, 0);
    chk("midrst_out_tag", out_tag, 0);
    chk("midrst_out_err", out_err, 0);
    rst_n = 1'b1;
    tick();
    #1 chk("midrst_in_ready", in_ready, 1);
    issue(32'hC000_0003, 5'd30, 3'd2, 5'd18, tries);
    drain("drain_after_reset");

    // Randomized traffic with random output backpressure.
    rand_bp = 1'b1;
    for (int k = 0; k < 300; k++)
      issue($urandom, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)), tries);
    drain("drain_random");
    rand_bp = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
